// File: rtl/gp_axis_pingpong_if_pkg.sv
// Shared encodings for gp_axis_pingpong_if: bank states, core FSM states and
// an index-width helper for the buffer memories.
package gp_axis_pingpong_if_pkg;

  localparam int unsigned BANK_STATE_WIDTH = 2;
  localparam logic [BANK_STATE_WIDTH-1:0] BANK_EMPTY = 2'd0;
  localparam logic [BANK_STATE_WIDTH-1:0] BANK_FULL  = 2'd1;
  localparam logic [BANK_STATE_WIDTH-1:0] BANK_BUSY  = 2'd2;

  localparam int unsigned C_STATE_WIDTH = 2;
  localparam logic [C_STATE_WIDTH-1:0] C_IDLE  = 2'd0;
  localparam logic [C_STATE_WIDTH-1:0] C_START = 2'd1;
  localparam logic [C_STATE_WIDTH-1:0] C_WAIT  = 2'd2;
  localparam logic [C_STATE_WIDTH-1:0] C_DRAIN = 2'd3;

  // Bits needed to index a memory of the given depth.
  function automatic int unsigned idxWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gp_axis_pingpong_bank.sv
// Two input banks with per-bank EMPTY/FULL/BUSY state, latched packet length
// and the write/read bank pointers.
module gp_axis_pingpong_bank #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IN_DEPTH     = 784,
  parameter int unsigned IN_ADR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrEn,
  input  logic [IN_ADR_WIDTH-1:0] wrAdr,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic                    wrClose,
  input  logic [IN_ADR_WIDTH-1:0] wrLen,
  input  logic                    claim,
  input  logic                    rdRelease,
  input  logic [IN_ADR_WIDTH-1:0] rdAdr,
  output logic                    wrReady,
  output logic                    rdFull,
  output logic [IN_ADR_WIDTH-1:0] rdLen,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic [1:0]              bankFull
);
  import gp_axis_pingpong_if_pkg::*;

  localparam int unsigned IDX_W = idxWidth(IN_DEPTH);

  logic [DATA_WIDTH-1:0]       mem       [2][IN_DEPTH];
  logic [BANK_STATE_WIDTH-1:0] bankState [2];
  logic [IN_ADR_WIDTH-1:0]     bankLen   [2];
  logic                        wrBank;
  logic                        rdBank;

  // Close, claim and release always target banks in different states, so
  // they never collide on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bankState[0] <= BANK_EMPTY;
      bankState[1] <= BANK_EMPTY;
      bankLen[0]   <= '0;
      bankLen[1]   <= '0;
      wrBank       <= 1'b0;
      rdBank       <= 1'b0;
    end else begin
      if (wrEn && wrClose) begin
        bankState[wrBank] <= BANK_FULL;
        bankLen[wrBank]   <= wrLen;
        wrBank            <= ~wrBank;
      end
      if (claim) begin
        bankState[rdBank] <= BANK_BUSY;
      end
      if (rdRelease) begin
        bankState[rdBank] <= BANK_EMPTY;
        rdBank            <= ~rdBank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrBank][wrAdr[IDX_W-1:0]] <= wrData;
    end
  end

  assign wrReady  = (bankState[wrBank] == BANK_EMPTY);
  assign rdFull   = (bankState[rdBank] == BANK_FULL);
  assign rdLen    = bankLen[rdBank];
  assign rdData   = (rdAdr < IN_ADR_WIDTH'(IN_DEPTH)) ? mem[rdBank][rdAdr[IDX_W-1:0]] : '0;
  assign bankFull = {bankState[1] != BANK_EMPTY, bankState[0] != BANK_EMPTY};

endmodule

// File: rtl/gp_axis_pingpong_if.sv
// AXI-Stream ping-pong wrapper between a DMA stream and a compute core.
// Defining GP_AXIS_LAST_CHECK_EN adds sticky s_last error reporting.
module gp_axis_pingpong_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IN_DEPTH      = 784,
  parameter int unsigned OUT_DEPTH     = 10,
  parameter int unsigned IN_ADR_WIDTH  = 10,
  parameter int unsigned OUT_ADR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     axisif_start,
  input  logic                     axisif_done,
  output logic [IN_ADR_WIDTH-1:0]  axisif_len,
  input  logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_adr,
  output logic [DATA_WIDTH-1:0]    axisif_bufferIn_data,
  input  logic [OUT_ADR_WIDTH-1:0] axisif_bufferOut_adr,
  input  logic [DATA_WIDTH-1:0]    axisif_bufferOut_data,
  input  logic                     axisif_bufferOut_wr,
`ifdef GP_AXIS_LAST_CHECK_EN
  output logic                     err_last,
  input  logic                     err_clr,
`endif
  output logic [1:0]               bank_full
);
  import gp_axis_pingpong_if_pkg::*;

  localparam int unsigned OUT_IDX_W = idxWidth(OUT_DEPTH);

  logic                     sBeat, wrAtEnd, wrClose;
  logic [IN_ADR_WIDTH-1:0]  wrCntQ, wrLen;
  logic                     claim, rdRelease, rdFull;
  logic [IN_ADR_WIDTH-1:0]  rdLen, lenQ;
  logic [C_STATE_WIDTH-1:0] stateQ, stateD;
  logic [OUT_ADR_WIDTH-1:0] outCntQ, outCntD;
  logic                     lastBeat;
  logic [DATA_WIDTH-1:0]    outBuf [OUT_DEPTH];

  assign sBeat   = s_valid & s_ready;
  assign wrAtEnd = (wrCntQ == IN_ADR_WIDTH'(IN_DEPTH - 1));
  assign wrClose = sBeat & (s_last | wrAtEnd);
  assign wrLen   = wrCntQ + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrCntQ <= '0;
    end else if (sBeat) begin
      wrCntQ <= wrClose ? '0 : wrLen;
    end
  end

  gp_axis_pingpong_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IN_DEPTH    (IN_DEPTH),
    .IN_ADR_WIDTH(IN_ADR_WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrEn     (sBeat),
    .wrAdr    (wrCntQ),
    .wrData   (s_data),
    .wrClose  (wrClose),
    .wrLen    (wrLen),
    .claim    (claim),
    .rdRelease(rdRelease),
    .rdAdr    (axisif_bufferIn_adr),
    .wrReady  (s_ready),
    .rdFull   (rdFull),
    .rdLen    (rdLen),
    .rdData   (axisif_bufferIn_data),
    .bankFull (bank_full)
  );

  assign lastBeat = (outCntQ == OUT_ADR_WIDTH'(OUT_DEPTH - 1));

  always_comb begin
    stateD    = stateQ;
    outCntD   = outCntQ;
    claim     = 1'b0;
    rdRelease = 1'b0;
    unique case (stateQ)
      C_IDLE:  if (rdFull) stateD = C_START;
      C_START: begin
        claim  = 1'b1;
        stateD = C_WAIT;
      end
      C_WAIT: if (axisif_done) begin
        rdRelease = 1'b1;
        outCntD   = '0;
        stateD    = C_DRAIN;
      end
      C_DRAIN: if (m_ready) begin
        if (lastBeat) stateD = C_IDLE;
        else          outCntD = outCntQ + 1'b1;
      end
      default: stateD = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= C_IDLE;
      outCntQ <= '0;
      lenQ    <= '0;
    end else begin
      stateQ  <= stateD;
      outCntQ <= outCntD;
      if (stateQ == C_IDLE && rdFull) lenQ <= rdLen;
    end
  end

  always_ff @(posedge clk) begin
    if (axisif_bufferOut_wr && stateQ == C_WAIT &&
        axisif_bufferOut_adr < OUT_ADR_WIDTH'(OUT_DEPTH)) begin
      outBuf[axisif_bufferOut_adr[OUT_IDX_W-1:0]] <= axisif_bufferOut_data;
    end
  end

  assign axisif_start = (stateQ == C_START);
  assign axisif_len   = lenQ;
  assign m_valid      = (stateQ == C_DRAIN);
  assign m_last       = m_valid & lastBeat;
  assign m_data       = outBuf[outCntQ[OUT_IDX_W-1:0]];

`ifdef GP_AXIS_LAST_CHECK_EN
  logic errSet, errQ;

  // Missing s_last on the final word, or s_last on any earlier word.
  assign errSet = sBeat & (wrAtEnd ? ~s_last : s_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       errQ <= 1'b0;
    else if (errSet)  errQ <= 1'b1;
    else if (err_clr) errQ <= 1'b0;
  end

  assign err_last = errQ;
`endif

endmodule

// File: tb/tb_gp_axis_pingpong_if.sv
// Bench for gp_axis_pingpong_if: directed scenarios plus a randomized phase,
// checked against a queue-based packet/result model.
module tb_gp_axis_pingpong_if;

  localparam int unsigned DW   = 32;
  localparam int unsigned IND  = 8;
  localparam int unsigned OUTD = 4;
  localparam int unsigned IAW  = 4;
  localparam int unsigned OAW  = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  s_data;
  logic           s_valid, s_last, s_ready;
  logic [DW-1:0]  m_data;
  logic           m_valid, m_last, m_ready;
  logic           axisif_start, axisif_done;
  logic [IAW-1:0] axisif_len, axisif_bufferIn_adr;
  logic [DW-1:0]  axisif_bufferIn_data;
  logic [OAW-1:0] axisif_bufferOut_adr;
  logic [DW-1:0]  axisif_bufferOut_data;
  logic           axisif_bufferOut_wr;
  logic [1:0]     bank_full;
`ifdef GP_AXIS_LAST_CHECK_EN
  logic           err_last, err_clr;
`endif

  gp_axis_pingpong_if #(
    .DATA_WIDTH   (DW),
    .IN_DEPTH     (IND),
    .OUT_DEPTH    (OUTD),
    .IN_ADR_WIDTH (IAW),
    .OUT_ADR_WIDTH(OAW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_last               (s_last),
    .s_ready              (s_ready),
    .m_data               (m_data),
    .m_valid              (m_valid),
    .m_last               (m_last),
    .m_ready              (m_ready),
    .axisif_start         (axisif_start),
    .axisif_done          (axisif_done),
    .axisif_len           (axisif_len),
    .axisif_bufferIn_adr  (axisif_bufferIn_adr),
    .axisif_bufferIn_data (axisif_bufferIn_data),
    .axisif_bufferOut_adr (axisif_bufferOut_adr),
    .axisif_bufferOut_data(axisif_bufferOut_data),
    .axisif_bufferOut_wr  (axisif_bufferOut_wr),
`ifdef GP_AXIS_LAST_CHECK_EN
    .err_last             (err_last),
    .err_clr              (err_clr),
`endif
    .bank_full            (bank_full)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Model state: words and lengths of closed-or-filling packets, expected results.
  logic [DW-1:0] wordQ[$];
  int            lenQ[$];
  int            curLen = 0;
  logic [DW-1:0] outQ[$];
  int            svcCount = 0;
  bit            readyPat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A packet closes on s_last or once it holds IND words.
  function automatic void modelAccept(input logic [DW-1:0] w, input logic last);
    wordQ.push_back(w);
    curLen++;
    if (last || curLen == int'(IND)) begin
      lenQ.push_back(curLen);
      curLen = 0;
    end
  endfunction

  task automatic sendPkt(input int n, input bit useLast, input bit rnd,
                         input logic [DW-1:0] base, output int stalls);
    logic [DW-1:0] w;
    int guard;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      w       = rnd ? $urandom : base + 32'(i);
      s_valid = 1'b1;
      s_data  = w;
      s_last  = useLast && (i == n - 1);
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 400) begin
        tick();
        guard++;
        stalls++;
      end
      if (guard >= 400) begin
        checkEq("sReadyTimeout", 32'(guard), 32'(0));
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      modelAccept(w, s_last);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Acts as the compute core for one packet: check length and bank contents,
  // write results, then signal done.
  task automatic serviceOne(input int hold, input bit fixedRes);
    int guard = 0;
    int len;
    logic [DW-1:0] res;
    while (axisif_start !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400 || lenQ.size() == 0) begin
      checkEq("startTimeout", 32'(guard), 32'(0));
      return;
    end
    len = lenQ.pop_front();
    checkEq("len", 32'(axisif_len), 32'(len));
    tick();
    checkEq("startPulse", 32'(axisif_start), 32'(0));
    checkEq("lenHeld", 32'(axisif_len), 32'(len));
    for (int i = 0; i < len; i++) begin
      axisif_bufferIn_adr = IAW'(i);
      #1;
      checkEq("bufIn", axisif_bufferIn_data, wordQ.pop_front());
    end
    @(posedge clk);
    #1;
    repeat (hold) tick();
    for (int k = 0; k < int'(OUTD); k++) begin
      res = fixedRes ? 32'(10 + k) : $urandom;
      outQ.push_back(res);
      axisif_bufferOut_adr  = OAW'(k);
      axisif_bufferOut_data = res;
      axisif_bufferOut_wr   = 1'b1;
      tick();
    end
    axisif_bufferOut_wr = 1'b0;
    axisif_done = 1'b1;
    tick();
    axisif_done = 1'b0;
    checkEq("reoffer", 32'(bank_full[svcCount[0]]), 32'(0));
    checkEq("readyAfterDone", 32'(s_ready), 32'(1));
    checkEq("mValidLat", 32'(m_valid), 32'(1));
    svcCount++;
  endtask

  // mode 0: random m_ready, 1: fixed pattern, 2: always ready.
  task automatic drainOne(input int mode);
    int  guard = 0;
    bit  r;
    logic [DW-1:0] w;
    while (outQ.size() > 0 && guard < 200) begin
      if (mode == 1)      r = (guard < 5) ? readyPat[guard] : 1'b1;
      else if (mode == 2) r = 1'b1;
      else                r = 1'($urandom_range(0, 1));
      m_ready = r;
      checkEq("mValid", 32'(m_valid), 32'(1));
      checkEq("mData", m_data, outQ[0]);
      checkEq("mLast", 32'(m_last), 32'(outQ.size() == 1));
      if (r) w = outQ.pop_front();
      tick();
      guard++;
    end
    m_ready = 1'b0;
    checkEq("idleAfterDrain", 32'(m_valid), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, stB, stC, lat, n;
    bit ul;
    rst_n = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    axisif_done = 1'b0; axisif_bufferIn_adr = '0; axisif_bufferOut_adr = '0;
    axisif_bufferOut_data = '0; axisif_bufferOut_wr = 1'b0;
`ifdef GP_AXIS_LAST_CHECK_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    checkEq("rstReady", 32'(s_ready), 32'(1));
    checkEq("rstMValid", 32'(m_valid), 32'(0));
    checkEq("rstMLast", 32'(m_last), 32'(0));
    checkEq("rstStart", 32'(axisif_start), 32'(0));
    checkEq("rstLen", 32'(axisif_len), 32'(0));
    checkEq("rstBankFull", 32'(bank_full), 32'(0));

    // done outside C_WAIT is ignored
    axisif_done = 1'b1;
    tick();
    axisif_done = 1'b0;
    checkEq("doneIgnored", 32'(m_valid), 32'(0));
    tick();
    checkEq("doneIgnored2", 32'(m_valid), 32'(0));

    // Full 8-word packet 1..8, start 2 cycles after the last beat
    sendPkt(8, 1'b1, 1'b0, 32'd1, st);
    checkEq("closeBankFull", 32'(bank_full), 32'(1));
    lat = 1;
    while (axisif_start !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkEq("startLatency", 32'(lat), 32'(2));
    serviceOne(0, 1'b0);
    drainOne(2);

    // Back-to-back packets: second fills the other bank without stalling
    fork
      begin
        sendPkt(8, 1'b1, 1'b1, 32'd0, st);
        sendPkt(8, 1'b1, 1'b1, 32'd0, stB);
        checkEq("noStallB", 32'(stB), 32'(0));
        checkEq("bothFull", 32'(bank_full), 32'(3));
        checkEq("readyLowFull", 32'(s_ready), 32'(0));
        sendPkt(8, 1'b1, 1'b0, 32'd100, stC);
        checkEq("stallC", 32'(stC > 0), 32'(1));
      end
      begin
        serviceOne(20, 1'b0);
        drainOne(0);
        serviceOne(0, 1'b0);
        drainOne(0);
        serviceOne(0, 1'b0);
        drainOne(0);
      end
    join

    // Short packet; next packet lands at address 0 of the other bank
    sendPkt(3, 1'b1, 1'b1, 32'd0, st);
    fork
      sendPkt(5, 1'b1, 1'b1, 32'd0, stB);
      begin
        serviceOne(2, 1'b0);
        drainOne(0);
        serviceOne(0, 1'b0);
        drainOne(0);
      end
    join

    // Results 10..13 drained with m_ready 1,0,1,1,1
    sendPkt(4, 1'b1, 1'b1, 32'd0, st);
    serviceOne(0, 1'b1);
    drainOne(1);

    // Randomized traffic, including headless full-length packets
    fork
      begin
        for (int p = 0; p < 14; p++) begin
          n  = $urandom_range(1, IND);
          ul = (n < int'(IND)) ? 1'b1 : 1'($urandom_range(0, 1));
          sendPkt(n, ul, 1'b1, 32'd0, st);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int p = 0; p < 14; p++) begin
          serviceOne($urandom_range(0, 6), 1'b0);
          drainOne(0);
        end
      end
    join

`ifdef GP_AXIS_LAST_CHECK_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkEq("errCleared0", 32'(err_last), 32'(0));
    sendPkt(8, 1'b0, 1'b1, 32'd0, st);
    checkEq("errNoLast", 32'(err_last), 32'(1));
    serviceOne(0, 1'b0);
    drainOne(2);
    checkEq("errSticky", 32'(err_last), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkEq("errCleared", 32'(err_last), 32'(0));
`endif

    // Reset during C_DRAIN
    sendPkt(2, 1'b1, 1'b1, 32'd0, st);
    serviceOne(0, 1'b0);
    m_ready = 1'b0;
    checkEq("drainBeforeRst", 32'(m_valid), 32'(1));
    #3 rst_n = 1'b0;
    #1;
    checkEq("rstMidValid", 32'(m_valid), 32'(0));
    checkEq("rstMidLast", 32'(m_last), 32'(0));
    outQ.delete();
    lenQ.delete();
    wordQ.delete();
    curLen   = 0;
    svcCount = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkEq("postRstBankFull", 32'(bank_full), 32'(0));
    checkEq("postRstReady", 32'(s_ready), 32'(1));
    checkEq("postRstLen", 32'(axisif_len), 32'(0));

    // Operation resumes cleanly from bank 0
    sendPkt(5, 1'b1, 1'b1, 32'd0, st);
    serviceOne(1, 1'b0);
    drainOne(0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/gp_axis_pingpong_if.md
Name: gp_axis_pingpong_if

Overview:
Second-generation AXI-Stream wrapper between a DMA stream and a compute core (CNN layer engine).
- Input side is ping-pong double-buffered: the slave fills one bank while the core processes the other.
- Packets may be shorter than IN_DEPTH; s_last terminates a packet and the received length is passed to the core.
- Results are written by the core into an output buffer, then drained on the master stream with m_last.

Parameters:
DATA_WIDTH, 32, stream and buffer word width
IN_DEPTH, 784, words per input bank (max packet length)
OUT_DEPTH, 10, words per result packet
IN_ADR_WIDTH, 10, input address/length width; must satisfy 2^IN_ADR_WIDTH > IN_DEPTH
OUT_ADR_WIDTH, 4, output address width; must satisfy 2^OUT_ADR_WIDTH >= OUT_DEPTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
s_data  in  DATA_WIDTH  slave stream data
s_valid  in  1  slave valid
s_last  in  1  slave end of packet
s_ready  out  1  slave ready
m_data  out  DATA_WIDTH  master stream data
m_valid  out  1  master valid
m_last  out  1  master end of packet
m_ready  in  1  master ready
axisif_start  out  1  one-cycle pulse: core may start on the current read bank
axisif_done  in  1  core finished; results are in the output buffer
axisif_len  out  IN_ADR_WIDTH  word count of the packet being processed; held from start until done
axisif_bufferIn_adr  in  IN_ADR_WIDTH  core read address into the current read bank
axisif_bufferIn_data  out  DATA_WIDTH  asynchronous read data from the current read bank
axisif_bufferOut_adr  in  OUT_ADR_WIDTH  core write address, output buffer
axisif_bufferOut_data  in  DATA_WIDTH  core write data
axisif_bufferOut_wr  in  1  core write enable; honoured only in C_WAIT
bank_full  out  2  per-bank FULL-or-BUSY status, for debug

Behaviour:
- Reset (async assert, sync release):
  - both banks EMPTY; wr_bank=0, rd_bank=0; all counters 0; core FSM in C_IDLE.
  - s_ready=1 after release; m_valid=0, m_last=0, axisif_start=0, axisif_len=0.
  - A reset mid-operation discards all packet data.
- Bank states: EMPTY -> FULL -> BUSY -> EMPTY. State updates are registered.
- Slave side:
  - s_ready = (bank[wr_bank]==EMPTY).
  - On a beat (s_valid & s_ready): write bank[wr_bank][wr_cnt], then wr_cnt++.
  - The packet closes on s_last or when wr_cnt==IN_DEPTH-1. On close: latch len=wr_cnt+1, mark the bank FULL, toggle wr_bank, clear wr_cnt.
  - A length of 1 is legal.
  - A packet that reaches IN_DEPTH words without s_last closes anyway; subsequent beats start a new packet.
- Core FSM:
  - C_IDLE: if bank[rd_bank]==FULL, go to C_START.
  - C_START: axisif_start=1 for one cycle, mark the bank BUSY, drive axisif_len; go to C_WAIT.
  - C_WAIT: wait for axisif_done. When it arrives, mark bank[rd_bank] EMPTY, toggle rd_bank, clear out_cnt; go to C_DRAIN.
  - C_DRAIN: m_valid=1, m_data=outbuf[out_cnt] (asynchronous read). out_cnt++ on m_ready. m_last=1 while out_cnt==OUT_DEPTH-1. After the last beat, go to C_IDLE.
- Latency:
  - Slave close to axisif_start: 2 cycles when C_IDLE.
  - done to first m_valid: 1 cycle.
  - A drained bank is re-offered to the slave 1 cycle after done.
- m_data, m_valid and m_last stay stable while m_valid & ~m_ready.
- Simultaneous events:
  - A slave close and a core claim of the other bank in the same cycle are both honoured.
  - done asserted in the same cycle the slave fills the freed bank's partner is legal.
  - axisif_done outside C_WAIT is ignored.
- Throughput: the slave can refill the next bank throughout C_START, C_WAIT and C_DRAIN. s_ready drops only when both banks are non-EMPTY.

Optional Feature:
Macro GP_AXIS_LAST_CHECK_EN.
- Defined: adds ports err_last (out, 1, sticky) and err_clr (in, 1).
  - err_last sets when s_last is absent on word IN_DEPTH.
  - err_last also sets when s_last arrives on any word other than the expected one and the packet length is < IN_DEPTH.
  - err_clr clears err_last the next cycle; a set condition in the same cycle wins.
- Undefined: the ports are absent, and short and headless packets are accepted silently.

Decomposition:
- Shared header gp_axis_defs.vh: bank state encodings (EMPTY/FULL/BUSY), core FSM state encodings with C_STATE_WIDTH, width-check macros.
- One sub-module, gp_axis_pingpong_bank: two IN_DEPTH banks, per-bank state and length registers, wr_bank/rd_bank pointers.

Test Plan:
- IN_DEPTH=8, one 8-word packet 1..8 with s_last on beat 8 -> axisif_start 2 cycles after the last beat; axisif_len=8; core reads 1..8.
- Two back-to-back 8-word packets, done held off 20 cycles -> second packet fills bank 1 without stall; s_ready=0 only on a third packet until done.
- Short packet of 3 words with s_last -> axisif_len=3; the next packet lands in the other bank at address 0.
- Core writes 10..13 (OUT_DEPTH=4), m_ready toggles 1,0,1,1,1 -> m_data 10,11,11,12,13 with m_last only on 13; FSM returns to C_IDLE.
- Assert rst_n low during C_DRAIN -> m_valid=0 immediately; after release bank_full=00 and s_ready=1.
- With GP_AXIS_LAST_CHECK_EN, 8 words without s_last -> err_last=1; pulse err_clr -> err_last=0 next cycle.
